// File: rtl/cart_ram_sequencer_if.sv
// Bus bundle between the download/erase/CPU sources and the cartridge RAM sequencer.
// The sequencer takes the slave side; whoever drives downloads and CPU cycles takes master.
interface cart_ram_sequencer_if;
  logic        dl_active;
  logic [7:0]  dl_index;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        erase_req;
  logic [15:0] cpu_addr;
  logic        cpu_we_n;
  logic [7:0]  cpu_data;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_data;
  logic        cpu_reset;
  logic        busy;

  modport master (
    output dl_active, dl_index, dl_wr, dl_addr, dl_data, erase_req,
    output cpu_addr, cpu_we_n, cpu_data,
    input  mem_addr, mem_we, mem_data, cpu_reset, busy
  );

  modport slave (
    input  dl_active, dl_index, dl_wr, dl_addr, dl_data, erase_req,
    input  cpu_addr, cpu_we_n, cpu_data,
    output mem_addr, mem_we, mem_data, cpu_reset, busy
  );
endinterface

// File: rtl/cart_ram_sequencer.sv
// Arbitrates the console RAM port between ROM download, a zero-fill erase sweep and the CPU,
// holding the CPU in reset while a load or erase runs and for a settling tail afterwards.
module cart_ram_sequencer #(
  parameter logic [15:0] ERASE_START = 16'h7000,
  parameter logic [15:0] ERASE_END   = 16'hFFFF,
  parameter logic [15:0] CART_OFFSET = 16'hC000,
  parameter int          TAIL_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  cart_ram_sequencer_if.slave  bus
);

  localparam int CW = (TAIL_CYCLES < 1) ? 1 : $clog2(TAIL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ERASE, TAIL} state_t;

  state_t      state;
  state_t      state_next;
  logic [CW-1:0] tail_cnt;
  logic [15:0] erase_ptr;
  logic        erase_pending;
  logic        erase_req_d;
  logic        erase_edge;

  logic [15:0] mem_addr_c;
  logic        mem_we_c;
  logic [7:0]  mem_data_c;

  assign erase_edge = bus.erase_req & ~erase_req_d;

  // Download always wins; otherwise each mode decides its own exit, and the RAM port
  // is steered purely from the registered mode so nothing adds a cycle of latency.
  always_comb begin
    state_next = state;
    mem_addr_c = bus.cpu_addr;
    mem_data_c = bus.cpu_data;
    mem_we_c   = 1'b0;

    if (bus.dl_active) begin
      state_next = LOAD;
    end else begin
      case (state)
        IDLE:    if (erase_edge) state_next = ERASE;
        LOAD:    state_next = (erase_pending || erase_edge) ? ERASE : TAIL;
        ERASE:   if (erase_ptr == ERASE_END) state_next = TAIL;
        TAIL: begin
          if (erase_edge)            state_next = ERASE;
          else if (tail_cnt == '0)   state_next = IDLE;
        end
        default: state_next = TAIL;
      endcase
    end

    case (state)
      IDLE: mem_we_c = ~bus.cpu_we_n;
      LOAD: begin
        mem_addr_c = (bus.dl_index == 8'd0) ? bus.dl_addr : bus.dl_addr + CART_OFFSET;
        mem_data_c = bus.dl_data;
        mem_we_c   = bus.dl_wr;
      end
      ERASE: begin
        mem_addr_c = erase_ptr;
        mem_data_c = 8'h00;
        mem_we_c   = 1'b1;
      end
      default: mem_we_c = 1'b0;
    endcase
  end

  // Outside an active sweep the pointer parks at ERASE_START, so every sweep (fresh or
  // after an abort) starts from the bottom and the pointer can never wrap past ERASE_END.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= TAIL;
      tail_cnt      <= CW'(TAIL_CYCLES);
      erase_ptr     <= ERASE_START;
      erase_pending <= 1'b0;
      erase_req_d   <= 1'b0;
    end else begin
      state       <= state_next;
      erase_req_d <= bus.erase_req;

      if (state_next == TAIL && state != TAIL)
        tail_cnt <= CW'(TAIL_CYCLES);
      else if (state == TAIL && tail_cnt != '0)
        tail_cnt <= tail_cnt - CW'(1);

      if (state == ERASE && state_next == ERASE)
        erase_ptr <= erase_ptr + 16'd1;
      else
        erase_ptr <= ERASE_START;

      if (state_next == ERASE && state != ERASE)
        erase_pending <= 1'b0;
      else if (state == ERASE)
        erase_pending <= 1'b0;
      else if (state == LOAD && erase_edge)
        erase_pending <= 1'b1;
    end
  end

  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_data  = mem_data_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.cpu_reset = (state != IDLE);
  assign bus.busy      = (state == LOAD) || (state == ERASE);

endmodule

// File: tb/tb_cart_ram_sequencer.sv
// Scenario bench for cart_ram_sequencer: each task drives one behaviour and compares the RAM
// port and status outputs against values derived from the address/timing rules of the block.
module tb_cart_ram_sequencer;
  localparam logic [15:0] ERASE_START = 16'h7000;
  localparam logic [15:0] ERASE_END   = 16'hFFFF;
  localparam logic [15:0] CART_OFFSET = 16'hC000;
  localparam int          TAIL_CYCLES = 255;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  cart_ram_sequencer_if bus();

  cart_ram_sequencer #(
    .ERASE_START(ERASE_START), .ERASE_END(ERASE_END),
    .CART_OFFSET(CART_OFFSET), .TAIL_CYCLES(TAIL_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  // Reference address map for downloaded bytes: image 0 lands as-is, others shift by the offset.
  function automatic logic [15:0] ref_load_addr(input logic [7:0] idx, input logic [15:0] a);
    int sum;
    sum = (idx == 8'd0) ? int'(a) : (int'(a) + int'(CART_OFFSET)) % 65536;
    return sum[15:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Counts cycles of CPU reset hold without busy, starting from the current settled cycle.
  task automatic measure_tail(output int n, output int we_seen);
    n = 0;
    we_seen = 0;
    while (bus.cpu_reset === 1'b1 && bus.busy === 1'b0 && n < 2000) begin
      n++;
      if (bus.mem_we !== 1'b0) we_seen++;
      next_cycle();
      settle();
    end
  endtask

  task automatic test_reset();
    int n, we;
    reset = 1'b1;
    bus.dl_active = 1'b0; bus.dl_index = 8'd0; bus.dl_wr = 1'b0;
    bus.dl_addr = 16'd0; bus.dl_data = 8'd0; bus.erase_req = 1'b0;
    bus.cpu_addr = 16'h1234; bus.cpu_we_n = 1'b0; bus.cpu_data = 8'h3C;
    repeat (3) next_cycle();
    reset = 1'b0;
    settle();
    checks++; if (bus.cpu_reset !== 1'b1) $display("[TB] FAIL reset_cpu_reset: got %b want 1", bus.cpu_reset); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL reset_mem_we: got %b want 0", bus.mem_we); else passed++;
    measure_tail(n, we);
    checks++; if (n != TAIL_CYCLES + 1) $display("[TB] FAIL reset_tail_len: got %0d want %0d", n, TAIL_CYCLES + 1); else passed++;
    checks++; if (we != 0) $display("[TB] FAIL tail_cpu_write_blocked: got %0d writes want 0", we); else passed++;
    checks++; if (bus.cpu_reset !== 1'b0) $display("[TB] FAIL idle_cpu_reset: got %b want 0", bus.cpu_reset); else passed++;
    checks++; if (bus.mem_we !== 1'b1) $display("[TB] FAIL idle_mem_we: got %b want 1", bus.mem_we); else passed++;
    checks++; if (bus.mem_addr !== 16'h1234) $display("[TB] FAIL idle_mem_addr: got %h want 1234", bus.mem_addr); else passed++;
  endtask

  task automatic test_idle_passthrough();
    for (int i = 0; i < 24; i++) begin
      next_cycle();
      bus.cpu_addr = 16'($urandom);
      bus.cpu_data = 8'($urandom);
      bus.cpu_we_n = 1'($urandom);
      settle();
      checks++; if (bus.mem_addr !== bus.cpu_addr) $display("[TB] FAIL idle_addr: got %h want %h", bus.mem_addr, bus.cpu_addr); else passed++;
      checks++; if (bus.mem_data !== bus.cpu_data) $display("[TB] FAIL idle_data: got %h want %h", bus.mem_data, bus.cpu_data); else passed++;
      checks++; if (bus.mem_we !== ~bus.cpu_we_n) $display("[TB] FAIL idle_we: got %b want %b", bus.mem_we, ~bus.cpu_we_n); else passed++;
    end
    next_cycle();
    bus.cpu_we_n = 1'b1;
    settle();
  endtask

  task automatic test_load();
    int n, we;
    logic [15:0] exp_addr;
    next_cycle(); bus.dl_active = 1'b1; bus.dl_wr = 1'b0; settle();
    next_cycle(); settle();
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL load_busy: got %b want 1", bus.busy); else passed++;
    checks++; if (bus.cpu_reset !== 1'b1) $display("[TB] FAIL load_cpu_reset: got %b want 1", bus.cpu_reset); else passed++;
    next_cycle();
    bus.dl_index = 8'd1; bus.dl_addr = 16'h0010; bus.dl_data = 8'hA5; bus.dl_wr = 1'b1;
    settle();
    checks++; if (bus.mem_addr !== 16'hC010) $display("[TB] FAIL load_cart_addr: got %h want c010", bus.mem_addr); else passed++;
    checks++; if (bus.mem_we !== 1'b1) $display("[TB] FAIL load_we: got %b want 1", bus.mem_we); else passed++;
    checks++; if (bus.mem_data !== 8'hA5) $display("[TB] FAIL load_data: got %h want a5", bus.mem_data); else passed++;
    next_cycle(); bus.dl_index = 8'd0; settle();
    checks++; if (bus.mem_addr !== 16'h0010) $display("[TB] FAIL load_boot_addr: got %h want 0010", bus.mem_addr); else passed++;
    for (int i = 0; i < 24; i++) begin
      next_cycle();
      bus.dl_index = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      bus.dl_addr  = 16'($urandom);
      bus.dl_data  = 8'($urandom);
      bus.dl_wr    = 1'($urandom);
      bus.cpu_we_n = 1'($urandom);
      settle();
      exp_addr = ref_load_addr(bus.dl_index, bus.dl_addr);
      checks++; if (bus.mem_addr !== exp_addr) $display("[TB] FAIL load_rand_addr: got %h want %h", bus.mem_addr, exp_addr); else passed++;
      checks++; if (bus.mem_we !== bus.dl_wr) $display("[TB] FAIL load_rand_we: got %b want %b", bus.mem_we, bus.dl_wr); else passed++;
      checks++; if (bus.mem_data !== bus.dl_data) $display("[TB] FAIL load_rand_data: got %h want %h", bus.mem_data, bus.dl_data); else passed++;
    end
    next_cycle(); bus.dl_active = 1'b0; bus.dl_wr = 1'b0; bus.cpu_we_n = 1'b0; settle();
    next_cycle(); settle();
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL load_exit_busy: got %b want 0", bus.busy); else passed++;
    measure_tail(n, we);
    checks++; if (n != TAIL_CYCLES + 1) $display("[TB] FAIL load_tail_len: got %0d want %0d", n, TAIL_CYCLES + 1); else passed++;
    checks++; if (we != 0) $display("[TB] FAIL load_tail_we: got %0d writes want 0", we); else passed++;
    next_cycle(); bus.cpu_we_n = 1'b1; settle();
  endtask

  task automatic test_erase_sweep();
    int k, errs, n, we;
    logic [15:0] last;
    next_cycle(); bus.erase_req = 1'b1; settle();
    next_cycle(); settle();
    k = 0; errs = 0; last = 16'h0;
    while (bus.busy === 1'b1 && k < 40000) begin
      if (bus.mem_we !== 1'b1 || bus.mem_data !== 8'h00 || bus.mem_addr !== 16'(int'(ERASE_START) + k)) errs++;
      last = bus.mem_addr;
      k++;
      next_cycle();
      bus.erase_req = (k < 50 || k >= 100);
      settle();
    end
    checks++; if (k != int'(ERASE_END) - int'(ERASE_START) + 1) $display("[TB] FAIL erase_count: got %0d want %0d", k, int'(ERASE_END) - int'(ERASE_START) + 1); else passed++;
    checks++; if (errs != 0) $display("[TB] FAIL erase_sequence: got %0d bad cycles want 0", errs); else passed++;
    checks++; if (last !== ERASE_END) $display("[TB] FAIL erase_last_addr: got %h want %h", last, ERASE_END); else passed++;
    measure_tail(n, we);
    checks++; if (n != TAIL_CYCLES + 1) $display("[TB] FAIL erase_tail_len: got %0d want %0d", n, TAIL_CYCLES + 1); else passed++;
    checks++; if (bus.cpu_reset !== 1'b0) $display("[TB] FAIL erase_then_idle: got %b want 0", bus.cpu_reset); else passed++;
    next_cycle(); bus.erase_req = 1'b0; settle();
  endtask

  task automatic test_pending_and_abort();
    int k, errs, writes;
    next_cycle(); bus.dl_active = 1'b1; bus.dl_wr = 1'b0; settle();
    next_cycle(); settle();
    next_cycle(); bus.erase_req = 1'b1; settle();
    next_cycle(); bus.erase_req = 1'b0; settle();
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_we !== 1'b0) writes++;
      next_cycle(); settle();
    end
    checks++; if (writes != 0) $display("[TB] FAIL pending_no_writes: got %0d want 0", writes); else passed++;
    next_cycle(); bus.dl_active = 1'b0; settle();
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL pending_fall_we: got %b want 0", bus.mem_we); else passed++;
    next_cycle(); settle();
    checks++; if (bus.mem_addr !== ERASE_START) $display("[TB] FAIL pending_start_addr: got %h want %h", bus.mem_addr, ERASE_START); else passed++;
    checks++; if (bus.mem_we !== 1'b1) $display("[TB] FAIL pending_start_we: got %b want 1", bus.mem_we); else passed++;
    k = 0; errs = 0;
    while (bus.mem_addr !== 16'h8000 && k < 10000) begin
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'(int'(ERASE_START) + k)) errs++;
      k++;
      next_cycle(); settle();
    end
    checks++; if (k != 16'h8000 - int'(ERASE_START)) $display("[TB] FAIL abort_reach_8000: got %0d want %0d", k, 16'h8000 - int'(ERASE_START)); else passed++;
    checks++; if (errs != 0) $display("[TB] FAIL abort_sweep_seq: got %0d bad cycles want 0", errs); else passed++;
    bus.dl_active = 1'b1;
    next_cycle();
    bus.dl_index = 8'd0; bus.dl_addr = 16'h0042; bus.dl_data = 8'h5A; bus.dl_wr = 1'b1;
    settle();
    checks++; if (bus.mem_addr !== 16'h0042) $display("[TB] FAIL abort_load_addr: got %h want 0042", bus.mem_addr); else passed++;
    checks++; if (bus.mem_data !== 8'h5A) $display("[TB] FAIL abort_load_data: got %h want 5a", bus.mem_data); else passed++;
    next_cycle(); bus.dl_wr = 1'b0; settle();
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_we !== 1'b0) writes++;
      next_cycle(); settle();
    end
    checks++; if (writes != 0) $display("[TB] FAIL abort_no_zero_writes: got %0d want 0", writes); else passed++;
    next_cycle(); bus.dl_active = 1'b0; settle();
    next_cycle(); settle();
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL abort_pending_cleared: got busy %b want 0", bus.busy); else passed++;
    next_cycle(); bus.erase_req = 1'b1; settle();
    next_cycle(); settle();
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_we !== 1'b1 || bus.busy !== 1'b1 || bus.mem_addr !== 16'(int'(ERASE_START) + i)) errs++;
      next_cycle(); settle();
    end
    checks++; if (errs != 0) $display("[TB] FAIL restart_from_start: got %0d bad cycles want 0", errs); else passed++;
  endtask

  task automatic test_reset_mid_erase();
    int n, we;
    next_cycle(); reset = 1'b1; bus.dl_active = 1'b1; bus.erase_req = 1'b0; settle();
    next_cycle(); reset = 1'b0; settle();
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL rst_mid_we: got %b want 0", bus.mem_we); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %b want 0", bus.busy); else passed++;
    next_cycle(); settle();
    checks++; if (bus.busy !== 1'b1) $display("[TB] FAIL rst_reenter_load: got %b want 1", bus.busy); else passed++;
    checks++; if (bus.mem_we !== 1'b0) $display("[TB] FAIL rst_load_we: got %b want 0", bus.mem_we); else passed++;
    next_cycle(); bus.dl_active = 1'b0; settle();
    next_cycle(); settle();
    measure_tail(n, we);
    checks++; if (n != TAIL_CYCLES + 1) $display("[TB] FAIL rst_tail_len: got %0d want %0d", n, TAIL_CYCLES + 1); else passed++;
    checks++; if (bus.cpu_reset !== 1'b0) $display("[TB] FAIL rst_final_idle: got %b want 0", bus.cpu_reset); else passed++;
  endtask

  initial begin
    test_reset();
    test_idle_passthrough();
    test_load();
    test_erase_sweep();
    test_pending_and_abort();
    test_reset_mid_erase();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
